// File: rtl/ttt_turn_controller_if.sv
// rtl/ttt_turn_controller_if.sv - move input and draw request handshake bundle
// master = turn controller, slave = switch/renderer side.
interface ttt_turn_controller_if;
   logic       go;
   logic [3:0] square;
   logic       draw_ack;
   logic       draw_req;
   logic [3:0] draw_cell;
   logic       draw_player;

   modport master (
      input  go, square, draw_ack,
      output draw_req, draw_cell, draw_player
   );

   modport slave (
      output go, square, draw_ack,
      input  draw_req, draw_cell, draw_player
   );
endinterface

// File: rtl/ttt_turn_controller.sv
// rtl/ttt_turn_controller.sv - tic-tac-toe move validation, board ownership and win/tie sequencing
// Optional macro TTT_MOVE_TIMEOUT_EN forfeits the turn after TIMEOUT_CYCLES idle cycles in S_LOAD_SQ.
module ttt_turn_controller #(
   parameter logic FIRST_PLAYER = 1'b0
`ifdef TTT_MOVE_TIMEOUT_EN
   ,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   ttt_turn_controller_if.master bus,
   output logic [17:0]           board,
   output logic                  turn,
   output logic                  err_invalid,
   output logic                  game_over,
   output logic [1:0]            winner
);
   typedef enum logic [2:0] {
      S_LOAD_SQ,
      S_LOAD_SQ_WAIT,
      S_VALIDATE,
      S_WRITE,
      S_DRAW,
      S_CHECK,
      S_END
   } state_t;

   state_t     state;
   logic [3:0] sq_reg;
   logic [3:0] move_count;
   logic [1:0] sel_cell;
   logic       p1_line;
   logic       p2_line;
`ifdef TTT_MOVE_TIMEOUT_EN
   logic [31:0] idle_cnt;
`endif

   function automatic logic has_line(input logic [17:0] b, input logic [1:0] p);
      logic [1:0] c [9];
      for (int i = 0; i < 9; i++) c[i] = b[2*i +: 2];
      return (c[0] == p && c[1] == p && c[2] == p) ||
             (c[3] == p && c[4] == p && c[5] == p) ||
             (c[6] == p && c[7] == p && c[8] == p) ||
             (c[0] == p && c[3] == p && c[6] == p) ||
             (c[1] == p && c[4] == p && c[7] == p) ||
             (c[2] == p && c[5] == p && c[8] == p) ||
             (c[0] == p && c[4] == p && c[8] == p) ||
             (c[2] == p && c[4] == p && c[6] == p);
   endfunction

   // Only meaningful when sq_reg <= 8; the range test guards it in S_VALIDATE.
   assign sel_cell = 2'(board >> {sq_reg, 1'b0});
   assign p1_line  = has_line(board, 2'b01);
   assign p2_line  = has_line(board, 2'b10);

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_LOAD_SQ;
         board           <= '0;
         move_count      <= '0;
         turn            <= FIRST_PLAYER;
         sq_reg          <= '0;
         bus.draw_req    <= 1'b0;
         bus.draw_cell   <= '0;
         bus.draw_player <= 1'b0;
         err_invalid     <= 1'b0;
         game_over       <= 1'b0;
         winner          <= 2'b00;
`ifdef TTT_MOVE_TIMEOUT_EN
         idle_cnt        <= '0;
`endif
      end else begin
         err_invalid <= 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
         // Held at zero outside S_LOAD_SQ so every entry starts a fresh count.
         idle_cnt    <= '0;
`endif
         case (state)
            S_LOAD_SQ: begin
               if (bus.go) begin
                  sq_reg <= bus.square;
                  state  <= S_LOAD_SQ_WAIT;
               end
`ifdef TTT_MOVE_TIMEOUT_EN
               else if (idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
                  turn        <= ~turn;
                  err_invalid <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
`endif
            end
            S_LOAD_SQ_WAIT: begin
               if (!bus.go) state <= S_VALIDATE;
            end
            S_VALIDATE: begin
               if (sq_reg > 4'd8 || sel_cell != 2'b00) begin
                  err_invalid <= 1'b1;
                  state       <= S_LOAD_SQ;
               end else begin
                  state <= S_WRITE;
               end
            end
            S_WRITE: begin
               for (int i = 0; i < 9; i++) begin
                  if (sq_reg == 4'(i)) board[2*i +: 2] <= turn ? 2'b10 : 2'b01;
               end
               if (move_count != 4'd9) move_count <= move_count + 4'd1;
               bus.draw_cell   <= sq_reg;
               bus.draw_player <= turn;
               bus.draw_req    <= 1'b1;
               state           <= S_DRAW;
            end
            S_DRAW: begin
               if (bus.draw_ack) begin
                  bus.draw_req <= 1'b0;
                  state        <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (p1_line) begin
                  winner    <= 2'b01;
                  game_over <= 1'b1;
                  state     <= S_END;
               end else if (p2_line) begin
                  winner    <= 2'b10;
                  game_over <= 1'b1;
                  state     <= S_END;
               end else if (move_count == 4'd9) begin
                  winner    <= 2'b11;
                  game_over <= 1'b1;
                  state     <= S_END;
               end else begin
                  turn  <= ~turn;
                  state <= S_LOAD_SQ;
               end
            end
            S_END: begin
               game_over <= 1'b1;
            end
            default: state <= S_LOAD_SQ;
         endcase
      end
   end
endmodule
